// File: rtl/shared_pkg.sv
// Shared defaults, read-mode enum and parameter-legality helper for the sync FIFO family.
package shared_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Depth must be a power of two no smaller than 4.
    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable thresholds, occupancy count,
// status pulses and a standard or first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = shared_pkg::DEF_DATA_WIDTH,
    parameter int DEPTH      = shared_pkg::DEF_DEPTH,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       full,
    output logic                       empty,
    output logic                       almostfull,
    output logic                       almostempty,
    output logic [$clog2(DEPTH):0]     count
);
    import shared_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? shared_pkg::FWFT : STD;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1 || AEMPTY_TH < 1 || AEMPTY_TH >= AFULL_TH) begin : g_bad_th
        $error("sync_fifo_param: thresholds out of range");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] head;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(AFULL_TH)) && !full;
    assign almostempty = !empty && (count_q <= CW'(AEMPTY_TH));

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    if (MODE == shared_pkg::FWFT) begin : g_fwft
        assign data_out = empty ? '0 : head;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        always_ff @(posedge clk) begin
            if (!rst_n)      data_q <= '0;
            else if (rd_acc) data_q <= head;
        end
        assign data_out = data_q;
    end

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// against a fixed vector table, directed corner sequences and a queue-based reference.
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n, wr_en, rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_ack, s_ovf, s_udf, s_full, s_empty, s_af, s_ae;
    logic          f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae;
    logic [3:0]    s_cnt, f_cnt;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .data_out(s_dout), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_udf),
        .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .count(s_cnt));

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_udf),
        .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_cnt));

    int n_chk  = 0;
    int n_fail = 0;
    bit use_model = 1'b0;

    // Reference: a plain queue of stored words plus the last-popped word and pulses.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_std;
    bit            m_ack, m_ovf, m_udf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int  n;
        bit  e_full, e_empty, e_af, e_ae;
        n       = q.size();
        e_full  = (n == DP);
        e_empty = (n == 0);
        e_af    = (n >= 7) && !e_full;
        e_ae    = (n != 0) && (n <= 1);
        chk("std.count", 32'(s_cnt), 32'(n));
        chk("std.full", 32'(s_full), 32'(e_full));
        chk("std.empty", 32'(s_empty), 32'(e_empty));
        chk("std.afull", 32'(s_af), 32'(e_af));
        chk("std.aempty", 32'(s_ae), 32'(e_ae));
        chk("std.wr_ack", 32'(s_ack), 32'(m_ack));
        chk("std.overflow", 32'(s_ovf), 32'(m_ovf));
        chk("std.underflow", 32'(s_udf), 32'(m_udf));
        chk("std.data_out", 32'(s_dout), 32'(m_std));
        chk("fw.count", 32'(f_cnt), 32'(n));
        chk("fw.full", 32'(f_full), 32'(e_full));
        chk("fw.empty", 32'(f_empty), 32'(e_empty));
        chk("fw.afull", 32'(f_af), 32'(e_af));
        chk("fw.aempty", 32'(f_ae), 32'(e_ae));
        chk("fw.wr_ack", 32'(f_ack), 32'(m_ack));
        chk("fw.overflow", 32'(f_ovf), 32'(m_ovf));
        chk("fw.underflow", 32'(f_udf), 32'(m_udf));
        chk("fw.data_out", 32'(f_dout), e_empty ? 32'd0 : 32'(q[0]));
    endtask

    // Apply one cycle of stimulus; the model advances from its pre-edge state.
    task automatic cyc(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
        bit rok, wok;
        rst_n = r; wr_en = w; rd_en = rd; data_in = d;
        if (!r) begin
            q.delete();
            m_std = '0; m_ack = 0; m_ovf = 0; m_udf = 0;
        end else begin
            rok   = rd && (q.size() > 0);
            wok   = w && ((q.size() < DP) || rok);
            m_ack = wok;
            m_ovf = w && !wok;
            m_udf = rd && !rok;
            if (rok) m_std = q.pop_front();
            if (wok) q.push_back(d);
        end
        @(posedge clk);
        #1;
        if (use_model) check_all();
    endtask

    typedef struct {
        bit            wr, rd;
        logic [DW-1:0] din;
        int            cnt;
        bit            full, empty, af, ae, ack, ovf, udf;
        logic [DW-1:0] sdo, fdo;
    } vec_t;

    vec_t tv[18];

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // Fill 9 writes (last overflows), then drain 9 reads (last underflows).
        for (int i = 0; i < 9; i++) begin
            tv[i] = '{wr: 1, rd: 0, din: 16'(i + 1), cnt: (i < 8) ? i + 1 : 8,
                      full: (i >= 7), empty: 0, af: (i == 6), ae: (i == 0),
                      ack: (i < 8), ovf: (i == 8), udf: 0, sdo: 16'h0, fdo: 16'h0001};
        end
        for (int j = 0; j < 9; j++) begin
            tv[9 + j] = '{wr: 0, rd: 1, din: 16'hDEAD, cnt: (j < 8) ? 7 - j : 0,
                          full: 0, empty: (j >= 7), af: (j == 0), ae: (j == 6),
                          ack: 0, ovf: 0, udf: (j == 8),
                          sdo: (j < 8) ? 16'(j + 1) : 16'h0008,
                          fdo: (j < 7) ? 16'(j + 2) : 16'h0};
        end

        cyc(0, 1, 1, 16'h5555);
        chk("reset.count", 32'(s_cnt), 32'd0);
        chk("reset.empty", 32'(s_empty), 32'd1);
        chk("reset.flags", 32'({s_full, s_af, s_ae, s_ack, s_ovf, s_udf}), 32'd0);
        chk("reset.dout", 32'(s_dout), 32'd0);
        chk("reset.fw_dout", 32'(f_dout), 32'd0);

        for (int k = 0; k < 18; k++) begin
            cyc(1, tv[k].wr, tv[k].rd, tv[k].din);
            chk($sformatf("tv%0d.count", k), 32'(s_cnt), 32'(tv[k].cnt));
            chk($sformatf("tv%0d.flags", k), 32'({s_full, s_empty, s_af, s_ae}),
                32'({tv[k].full, tv[k].empty, tv[k].af, tv[k].ae}));
            chk($sformatf("tv%0d.pulses", k), 32'({s_ack, s_ovf, s_udf}),
                32'({tv[k].ack, tv[k].ovf, tv[k].udf}));
            chk($sformatf("tv%0d.std_dout", k), 32'(s_dout), 32'(tv[k].sdo));
            chk($sformatf("tv%0d.fw_dout", k), 32'(f_dout), 32'(tv[k].fdo));
        end

        use_model = 1'b1;

        // Simultaneous access at full and at empty.
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 16'(16'h0100 + i));
        cyc(1, 1, 1, 16'h0F0F);
        chk("full_both.count", 32'(s_cnt), 32'd8);
        chk("full_both.ovf", 32'(s_ovf), 32'd0);
        chk("full_both.dout", 32'(s_dout), 32'h0100);
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 16'h0123);
        chk("empty_both.count", 32'(s_cnt), 32'd1);
        chk("empty_both.udf", 32'(s_udf), 32'd1);
        chk("empty_both.ack", 32'(s_ack), 32'd1);

        // Interleaved write/read pairs spanning several pointer wraps.
        cyc(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 16'(i));
            cyc(1, 0, 1, 0);
            chk($sformatf("wrap%0d.dout", i), 32'(s_dout), 32'(i));
        end

        // FWFT: word is visible without rd_en, pop returns to zero.
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 16'hBEEF);
        chk("fwft.show", 32'(f_dout), 32'hBEEF);
        chk("fwft.not_empty", 32'(f_empty), 32'd0);
        cyc(1, 0, 1, 0);
        chk("fwft.pop_dout", 32'(f_dout), 32'd0);
        chk("fwft.pop_empty", 32'(f_empty), 32'd1);

        // Mid-stream reset discards contents; next write lands first.
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 16'(16'h0A00 + i));
        chk("mid.count5", 32'(s_cnt), 32'd5);
        cyc(0, 1, 0, 16'h7777);
        chk("mid.count", 32'(s_cnt), 32'd0);
        chk("mid.empty", 32'(s_empty), 32'd1);
        chk("mid.pulses", 32'({s_ack, s_ovf, s_udf}), 32'd0);
        cyc(1, 1, 0, 16'h00AA);
        chk("mid.fw_head", 32'(f_dout), 32'h00AA);
        cyc(1, 0, 1, 0);
        chk("mid.std_read", 32'(s_dout), 32'h00AA);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 99) < 50), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO, generalised in width and depth, with programmable almost-full/almost-empty thresholds, an occupancy count output and a selectable first-word-fall-through (FWFT) read mode. It is a reusable buffer between a producer and a consumer in the same clock domain. It keeps the existing status set: write acknowledge, overflow, underflow, full, empty, almost-full and almost-empty.

## Interface
Parameters:
- DATA_WIDTH, 16: word width in bits.
- DEPTH, 8: number of entries. Must be a power of two and at least 4; any other value is an elaboration error.
- AFULL_TH, DEPTH-1: almost-full threshold, 1..DEPTH-1.
- AEMPTY_TH, 1: almost-empty threshold, 1..DEPTH-1. Must be less than AFULL_TH.
- FWFT, 0: 0 selects standard registered read; 1 selects first-word-fall-through.

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- wr_en, in, 1: write request.
- rd_en, in, 1: read request (pop when FWFT=1).
- data_in, in, DATA_WIDTH: write data.
- data_out, out, DATA_WIDTH: read data.
- wr_ack, out, 1: registered pulse, write was accepted.
- overflow, out, 1: registered pulse, write was rejected.
- underflow, out, 1: registered pulse, read was rejected.
- full, empty, almostfull, almostempty, out, 1 each: occupancy flags.
- count, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- A read is accepted when rd_en=1 and empty=0. It pops the head word and advances rd_ptr.
- A write is accepted when wr_en=1 and either full=0 or a read is accepted in the same cycle. It stores data_in at wr_ptr and advances wr_ptr.
- Simultaneous requests:
  - Full, both requested: both are accepted and count is unchanged.
  - Empty, both requested: only the write is accepted; underflow pulses.
- count update: +1 on write only, −1 on read only, unchanged otherwise.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Flags are combinational from the registered count:
  - full = (count == DEPTH); empty = (count == 0).
  - almostfull = (count >= AFULL_TH) && !full.
  - almostempty = (count != 0) && (count <= AEMPTY_TH).
- wr_ack goes to 1 the cycle after an accepted write, else 0.
- overflow goes to 1 the cycle after wr_en=1 with the write rejected.
- underflow goes to 1 the cycle after rd_en=1 with the read rejected.
- Standard mode (FWFT=0): data_out is a register. It loads the head word on an accepted read and holds its value otherwise.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever empty=0, and 0 when empty=1. rd_en acknowledges the displayed word.
- Reset (rst_n=0 at a rising edge): rd_ptr, wr_ptr, count, data_out, wr_ack, overflow and underflow all go to 0, so empty=1 and every other flag is 0. Reset overrides wr_en and rd_en in the same cycle. Memory contents are not cleared and are not observable after reset.
- Reset asserted mid-stream discards all stored words; the next write lands at entry 0.

## Timing
- Write-to-flag latency: a write accepted at edge N changes count and flags immediately after edge N.
- Standard read latency: a read accepted at edge N presents its data on data_out after edge N (one cycle after rd_en is sampled).
- FWFT latency: the first write into an empty FIFO at edge N makes data_out valid after edge N, together with empty falling.
- FWFT pop: a pop at edge N shows the next word, or 0 if the FIFO becomes empty, after edge N.
- wr_ack, overflow and underflow are single-cycle pulses. They repeat every cycle the condition holds.
- No combinational path from wr_en or rd_en to any output.

## Structure
- shared_pkg holds:
  - default constants for DATA_WIDTH and DEPTH.
  - a mode enum, fifo_mode_e {STD, FWFT}.
  - a helper function that checks the DEPTH power-of-two rule.
- One sub-module, fifo_mem: a DEPTH×DATA_WIDTH array with synchronous write and asynchronous read, and no reset.
- Pointer, count and flag logic and the output registers live in sync_fifo_param.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=16, AFULL_TH=7, AEMPTY_TH=1.
- **Fill from empty:** write 0x0001..0x0008 on consecutive cycles → wr_ack pulses 8 times; almostfull=1 at count=7; full=1 at count=8. A 9th write → overflow=1 for one cycle, count stays 8.
- **Drain (STD mode):** from full, 8 reads → data_out shows 0x0001..0x0008 in order, one cycle after each rd_en; almostempty=1 at count=1; empty=1 at count=0. A 9th read → underflow=1 and data_out holds 0x0008.
- **Simultaneous full/empty access:** when full, wr_en=rd_en=1 → both accepted, count stays 8, no overflow. When empty, wr_en=rd_en=1 → count becomes 1, underflow=1.
- **Wrap-around:** run 20 interleaved write/read pairs with data = cycle index → output order matches input exactly across pointer wrap.
- **FWFT mode:** write 0xBEEF into an empty FIFO → data_out=0xBEEF the cycle after, with no rd_en. Pop → data_out=0, empty=1.
- **Mid-operation reset:** with count=5, hold rst_n=0 for one edge while wr_en=1 → count=0, empty=1, all pulses 0. The next write of 0x00AA is then read back first.
